// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one uart_tx.
// Optional ARB_TAG_EN: prefix each packet with a requester tag byte.
module uart_tx_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          HOLD_TIMEOUT = 1000,
    parameter logic [7:0]  TAG_BASE     = 8'h30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_HOLD,
        S_TAG
    } state_t;

    localparam logic [15:0] HT = 16'(HOLD_TIMEOUT);

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_gidx;
    logic        r_last_f;
    logic [15:0] r_hold;

    logic [7:0]      w_valid8;
    logic [7:0]      w_last8;
    logic [63:0]     w_data64;
    logic [7:0]      w_g_data;
    logic            w_any;
    logic [2:0]      w_idx;
    logic [3:0]      w_sum;
    logic [NREQ-1:0] w_pick_oh;
    logic [15:0]     w_hold_nxt;
    logic            w_hold_hit;

    // Zero-extend requester buses so 3-bit indices always fit.
    assign w_valid8 = 8'(req_valid);
    assign w_last8  = 8'(req_last);
    assign w_data64 = 64'(req_data);
    assign w_g_data = w_data64[{r_gidx, 3'b000} +: 8];

    // Hold counter saturates; a zero timeout never fires.
    assign w_hold_nxt = (r_hold == 16'hFFFF) ? r_hold : r_hold + 16'd1;
    assign w_hold_hit = (HT != 16'd0) && (w_hold_nxt == HT);

    // Round-robin pick: first valid requester scanning from ptr+1.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sum = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            if (w_sum >= 4'(NREQ))
                w_sum = w_sum - 4'(NREQ);
            if (w_valid8[w_sum[2:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[2:0];
            end
        end
    end

    // One-hot form of the picked index.
    always_comb begin
        w_pick_oh = '0;
        for (int i = 0; i < NREQ; i++)
            w_pick_oh[i] = (w_idx == 3'(i));
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'(NREQ - 1);
            r_gidx    <= '0;
            r_last_f  <= 1'b0;
            r_hold    <= '0;
            req_ready <= '0;
            tx_en     <= 1'b0;
            tx_data   <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            req_ready <= '0;
            timeout   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gidx <= w_idx;
                        grant  <= w_pick_oh;
                        busy   <= 1'b1;
`ifdef ARB_TAG_EN
                        tx_en   <= 1'b1;
                        tx_data <= TAG_BASE + {5'd0, w_idx};
                        r_state <= S_TAG;
`else
                        req_ready <= w_pick_oh;
                        r_state   <= S_LOAD;
`endif
                    end
                end
`ifdef ARB_TAG_EN
                S_TAG: begin
                    if (tx_rdy) begin
                        tx_en     <= 1'b0;
                        req_ready <= grant;
                        r_state   <= S_LOAD;
                    end
                end
`endif
                S_LOAD: begin
                    tx_data  <= w_g_data;
                    r_last_f <= w_last8[r_gidx];
                    tx_en    <= 1'b1;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (tx_rdy) begin
                        tx_en <= 1'b0;
                        if (r_last_f) begin
                            r_ptr   <= r_gidx;
                            grant   <= '0;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold  <= '0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_valid8[r_gidx]) begin
                        req_ready <= grant;
                        r_state   <= S_LOAD;
                    end else begin
                        r_hold <= w_hold_nxt;
                        if (w_hold_hit) begin
                            timeout <= 1'b1;
                            r_ptr   <= r_gidx;
                            grant   <= '0;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
